// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and requester indices for the memory arbiter
//
// Purpose: arbiter state encoding and requester index constants.
// Ports:   none (package).
package cpu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin pick, purely combinational
//
// Purpose: choose one eligible requester, favouring the one not granted last.
// Ports:
//   elig       in  [1:0] eligible requester mask
//   last_grant in        index of the most recent winner
//   valid      out       at least one requester is eligible
//   grant_idx  out       index of the winner (meaningful only when valid)
module rr_arbiter2 (
  input  logic [1:0] elig,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant_idx
);

  always_comb begin
    valid = |elig;
    if (&elig) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = elig[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA round-robin arbiter for the single memory port
//
// Purpose: grant one requester at a time, sequence its access with wait
//          states, return read data with a done pulse, abort hung accesses.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req/wr/addr/wdata          per-requester request, direction, address, data
//   gnt, done, err, rdata      owner grant, completion pulse, timeout flag, read data
//   busy                       arbiter not idle
//   mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata/mem_ready  external memory port
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [1:0]              wr,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              gnt,
  output logic [1:0]              done,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  mem_arb_state_e        state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0] elig;
  logic       pick_valid;
  logic       pick;

  // A requester being handed its done pulse is still holding a stale req.
  assign elig = req & ~done_q;

  rr_arbiter2 u_rr (
    .elig       (elig),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant_idx  (pick)
  );

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = ACCESS;
          owner_d      = pick;
          dir_d        = wr[pick];
          last_grant_d = pick;
          wait_cnt_d   = '0;
          gnt_d        = pick ? 2'b10 : 2'b01;
          mem_addr_d   = pick ? addr[REQ_DMA*ADDR_WIDTH +: ADDR_WIDTH]
                              : addr[REQ_CPU*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d  = pick ? wdata[REQ_DMA*DATA_WIDTH +: DATA_WIDTH]
                              : wdata[REQ_CPU*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ACCESS: begin
        // Ready in the final wait cycle still counts as success.
        if (mem_ready) begin
          if (!dir_q) begin
            rdata_d = mem_rdata;
          end
          done_d  = owner_q ? 2'b10 : 2'b01;
          gnt_d   = 2'b00;
          state_d = IDLE;
        end else if (wait_cnt_q == TMAX) begin
          done_d  = owner_q ? 2'b10 : 2'b01;
          err_d   = 1'b1;
          gnt_d   = 2'b00;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_rd    = (state_q == ACCESS) && !dir_q;
  assign mem_wr    = (state_q == ACCESS) && dir_q;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
